mos_wishbone_master: RTL and testbench
======================================

Name: mos_wishbone_master

Overview:
- Single-outstanding Wishbone classic-cycle initiator, the bus-master counterpart of the team's Wishbone register responders, e.g. the MOS 6502 decoder interface at 0x3000_0000.
- Accepts one command at a time (address, write data, direction) over a valid/ready port.
- Runs one Wishbone cycle per command and returns read data or a timeout error over a valid/ready response port.
- Used by on-chip sequencers and benches to drive responders.

Parameters:
- TIMEOUT_CYCLES, 16: max cycles in BUS state awaiting ack before abort; legal range 2..255.
- TO_W, 8: width of the timeout counter.

Ports:
- wb_clk_i  in  1  clock.
- wb_rst_i  in  1  reset, asynchronous, active-high.
- cmd_valid_i  in  1  command present.
- cmd_ready_o  out  1  command accepted when high with cmd_valid_i.
- cmd_we_i  in  1  1 = write, 0 = read.
- cmd_adr_i  in  32  byte address.
- cmd_dat_i  in  32  write data.
- rsp_valid_o  out  1  response present.
- rsp_ready_i  in  1  response consumed.
- rsp_dat_o  out  32  read data; 0 for writes and errors.
- rsp_err_o  out  1  1 = timeout abort.
- busy_o  out  1  high whenever state is not IDLE.
- wbm_cyc_o  out  1  Wishbone cycle.
- wbm_stb_o  out  1  Wishbone strobe.
- wbm_we_o  out  1  Wishbone write enable.
- wbm_sel_o  out  4  byte selects; constant 4'hF when stb is high, else 0.
- wbm_adr_o  out  32  Wishbone address.
- wbm_dat_o  out  32  Wishbone write data.
- wbm_dat_i  in  32  Wishbone read data.
- wbm_ack_i  in  1  Wishbone acknowledge.

Behaviour:
- Reset (async, wb_rst_i=1) forces all outputs and state to 0/IDLE immediately. This includes the cyc, stb, rsp and busy outputs, all data/address registers, and the counter. Reset mid-cycle abandons the transaction with no response.
- States: IDLE, BUS, RESP. All outputs are registered.
- IDLE:
  - cmd_ready_o=1.
  - On an edge with cmd_valid_i=1: latch adr/dat/we into the wbm_* registers, set cyc=stb=1, clear the counter, go to BUS.
  - The bus is driven the cycle after acceptance; latency from acceptance to stb high is 1 cycle.
- BUS:
  - cmd_ready_o=0; cyc/stb/we/adr/dat/sel held stable.
  - Each edge with wbm_ack_i=1: capture wbm_dat_i into rsp_dat_o for a read (0 for a write), rsp_err_o=0, drop cyc/stb/we/sel the same edge, rsp_valid_o=1, go to RESP.
  - Otherwise increment the counter. When the counter reaches TIMEOUT_CYCLES-1 without ack: drop the bus, rsp_dat_o=0, rsp_err_o=1, rsp_valid_o=1, go to RESP.
  - If ack arrives on the same edge the timeout would fire, ack wins.
- RESP:
  - rsp_valid_o and the response fields are held until an edge with rsp_ready_i=1.
  - On that edge, clear rsp_valid_o and go to IDLE. cmd_ready_o rises the next cycle, so there is at least one idle cycle with cyc=0 between transactions.
- Ack handling: wbm_ack_i is ignored in IDLE and RESP. Any ack level present on the first BUS cycle is accepted, because the responder registers ack on the same edge as its data.
- No pipelining, no burst, no err/rty inputs. Exactly one cycle is outstanding.
- The counter saturates and never wraps inside BUS.

Optional Feature:
- Macro: MOS_WBM_TIMEOUT_EN.
- Defined: timeout counter and abort behave as described above.
- Undefined: no counter is built. BUS waits indefinitely for ack, and rsp_err_o is tied to 0.

Test Plan:
- Write to the instruction register: cmd we=1, adr=0x30000000, dat=0x000000A9; responder acks 1 cycle after stb. Required: wbm_adr_o=0x30000000, wbm_dat_o=0xA9, wbm_sel_o=0xF during stb, then rsp_valid_o=1, rsp_err_o=0, rsp_dat_o=0.
- Read the ID register: cmd we=0, adr=0x30000010; responder returns 0xB000DEAD with ack. Required: rsp_dat_o=0xB000DEAD and cyc/stb low the cycle after ack.
- Timeout: read of adr=0x30000100 with ack never asserted, TIMEOUT_CYCLES=16. Required: stb high for exactly 16 cycles, then rsp_err_o=1, rsp_dat_o=0. With the macro undefined, stb stays high for at least 100 cycles.
- Backpressure: rsp_ready_i held 0 for 5 cycles after a read. Required: rsp_valid_o/rsp_dat_o stable, cmd_ready_o=0 throughout, a second cmd_valid_i is not accepted, cmd_ready_o=1 one cycle after rsp_ready_i.
- Reset mid-BUS: assert wb_rst_i asynchronously between edges while stb=1. Required: cyc/stb/busy/rsp_valid low immediately, cmd_ready_o=1 after release.
- Spurious ack: pulse wbm_ack_i in IDLE and RESP. Required: no state change and no extra response; the next command completes normally.

Source files
------------

// File: rtl/mos_wishbone_master.sv
// Single-outstanding Wishbone classic-cycle initiator: one command in, one bus cycle, one response out.
// Optional build macro MOS_WBM_TIMEOUT_EN adds the ack timeout counter and abort-with-error response.
module mos_wishbone_master #(
    parameter int unsigned TIMEOUT_CYCLES = 16,
    parameter int unsigned TO_W           = 8
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic        cmd_valid_i,
    output logic        cmd_ready_o,
    input  logic        cmd_we_i,
    input  logic [31:0] cmd_adr_i,
    input  logic [31:0] cmd_dat_i,
    output logic        rsp_valid_o,
    input  logic        rsp_ready_i,
    output logic [31:0] rsp_dat_o,
    output logic        rsp_err_o,
    output logic        busy_o,
    output logic        wbm_cyc_o,
    output logic        wbm_stb_o,
    output logic        wbm_we_o,
    output logic [3:0]  wbm_sel_o,
    output logic [31:0] wbm_adr_o,
    output logic [31:0] wbm_dat_o,
    input  logic [31:0] wbm_dat_i,
    input  logic        wbm_ack_i
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUS  = 2'd1,
        S_RESP = 2'd2
    } state_e;

    state_e      state_q, state_d;
    logic        cmd_ready_q, cmd_ready_d;
    logic        rsp_valid_q, rsp_valid_d;
    logic [31:0] rsp_dat_q, rsp_dat_d;
    logic        rsp_err_q, rsp_err_d;
    logic        busy_q, busy_d;
    logic        cyc_q, cyc_d;
    logic        stb_q, stb_d;
    logic        we_q, we_d;
    logic [3:0]  sel_q, sel_d;
    logic [31:0] adr_q, adr_d;
    logic [31:0] dat_q, dat_d;

    logic accept;
    logic to_hit;

    assign accept = (state_q == S_IDLE) && cmd_ready_q && cmd_valid_i;

`ifdef MOS_WBM_TIMEOUT_EN
    logic [TO_W-1:0] cnt_q, cnt_d;

    // Fires on the BUS cycle where the counter holds TIMEOUT_CYCLES-1, so stb is up exactly TIMEOUT_CYCLES cycles.
    assign to_hit = (state_q == S_BUS) && (cnt_q == TO_W'(TIMEOUT_CYCLES - 1));

    always_comb begin
        cnt_d = cnt_q;
        if (accept) begin
            cnt_d = '0;
        end else if (state_q == S_BUS && !wbm_ack_i && !to_hit) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign rsp_err_o = rsp_err_q;
`else
    assign to_hit    = 1'b0;
    assign rsp_err_o = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        cmd_ready_d = cmd_ready_q;
        rsp_valid_d = rsp_valid_q;
        rsp_dat_d   = rsp_dat_q;
        rsp_err_d   = rsp_err_q;
        busy_d      = busy_q;
        cyc_d       = cyc_q;
        stb_d       = stb_q;
        we_d        = we_q;
        sel_d       = sel_q;
        adr_d       = adr_q;
        dat_d       = dat_q;

        case (state_q)
            S_IDLE: begin
                cmd_ready_d = 1'b1;
                busy_d      = 1'b0;
                if (accept) begin
                    adr_d       = cmd_adr_i;
                    dat_d       = cmd_dat_i;
                    we_d        = cmd_we_i;
                    cyc_d       = 1'b1;
                    stb_d       = 1'b1;
                    sel_d       = 4'hF;
                    cmd_ready_d = 1'b0;
                    busy_d      = 1'b1;
                    state_d     = S_BUS;
                end
            end
            S_BUS: begin
                // Ack is checked first so it wins over a timeout on the same edge.
                if (wbm_ack_i) begin
                    rsp_dat_d   = we_q ? 32'h0 : wbm_dat_i;
                    rsp_err_d   = 1'b0;
                    rsp_valid_d = 1'b1;
                    cyc_d       = 1'b0;
                    stb_d       = 1'b0;
                    we_d        = 1'b0;
                    sel_d       = 4'h0;
                    state_d     = S_RESP;
                end else if (to_hit) begin
                    rsp_dat_d   = 32'h0;
                    rsp_err_d   = 1'b1;
                    rsp_valid_d = 1'b1;
                    cyc_d       = 1'b0;
                    stb_d       = 1'b0;
                    we_d        = 1'b0;
                    sel_d       = 4'h0;
                    state_d     = S_RESP;
                end
            end
            S_RESP: begin
                if (rsp_ready_i) begin
                    rsp_valid_d = 1'b0;
                    cmd_ready_d = 1'b1;
                    busy_d      = 1'b0;
                    state_d     = S_IDLE;
                end
            end
            default: begin
                state_d     = S_IDLE;
                cmd_ready_d = 1'b0;
                busy_d      = 1'b0;
                cyc_d       = 1'b0;
                stb_d       = 1'b0;
                sel_d       = 4'h0;
            end
        endcase
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state_q     <= S_IDLE;
            cmd_ready_q <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_dat_q   <= '0;
            rsp_err_q   <= 1'b0;
            busy_q      <= 1'b0;
            cyc_q       <= 1'b0;
            stb_q       <= 1'b0;
            we_q        <= 1'b0;
            sel_q       <= '0;
            adr_q       <= '0;
            dat_q       <= '0;
        end else begin
            state_q     <= state_d;
            cmd_ready_q <= cmd_ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_dat_q   <= rsp_dat_d;
            rsp_err_q   <= rsp_err_d;
            busy_q      <= busy_d;
            cyc_q       <= cyc_d;
            stb_q       <= stb_d;
            we_q        <= we_d;
            sel_q       <= sel_d;
            adr_q       <= adr_d;
            dat_q       <= dat_d;
        end
    end

    assign cmd_ready_o = cmd_ready_q;
    assign rsp_valid_o = rsp_valid_q;
    assign rsp_dat_o   = rsp_dat_q;
    assign busy_o      = busy_q;
    assign wbm_cyc_o   = cyc_q;
    assign wbm_stb_o   = stb_q;
    assign wbm_we_o    = we_q;
    assign wbm_sel_o   = sel_q;
    assign wbm_adr_o   = adr_q;
    assign wbm_dat_o   = dat_q;

endmodule

// File: tb/tb_mos_wishbone_master.sv
// Directed + randomized bench for mos_wishbone_master against a memory-map reference model.
// Works with MOS_WBM_TIMEOUT_EN defined or undefined.
module tb_mos_wishbone_master;

    localparam int          TO     = 16;
    localparam logic [31:0] ID_ADR = 32'h3000_0010;

    logic        wb_clk_i = 1'b0;
    logic        wb_rst_i;
    logic        cmd_valid_i, cmd_ready_o, cmd_we_i;
    logic [31:0] cmd_adr_i, cmd_dat_i;
    logic        rsp_valid_o, rsp_ready_i, rsp_err_o, busy_o;
    logic [31:0] rsp_dat_o;
    logic        wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_ack_i;
    logic [3:0]  wbm_sel_o;
    logic [31:0] wbm_adr_o, wbm_dat_o, wbm_dat_i;

    int n_chk = 0;
    int n_err = 0;

    logic [31:0] ref_mem [logic [31:0]];
    logic [31:0] bus_mem [logic [31:0]];

    always #5 wb_clk_i = ~wb_clk_i;

    mos_wishbone_master #(.TIMEOUT_CYCLES(TO), .TO_W(8)) dut (
        .wb_clk_i(wb_clk_i), .wb_rst_i(wb_rst_i),
        .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o), .cmd_we_i(cmd_we_i),
        .cmd_adr_i(cmd_adr_i), .cmd_dat_i(cmd_dat_i),
        .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i), .rsp_dat_o(rsp_dat_o),
        .rsp_err_o(rsp_err_o), .busy_o(busy_o),
        .wbm_cyc_o(wbm_cyc_o), .wbm_stb_o(wbm_stb_o), .wbm_we_o(wbm_we_o),
        .wbm_sel_o(wbm_sel_o), .wbm_adr_o(wbm_adr_o), .wbm_dat_o(wbm_dat_o),
        .wbm_dat_i(wbm_dat_i), .wbm_ack_i(wbm_ack_i)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Reference: ID register is read-only, written words read back, untouched words read as ~address.
    function automatic logic [31:0] model_rd(input logic [31:0] a);
        if (a == ID_ADR) return 32'hB000_DEAD;
        if (ref_mem.exists(a)) return ref_mem[a];
        return ~a;
    endfunction

    function automatic logic [31:0] resp_rd(input logic [31:0] a);
        if (a == ID_ADR) return 32'hB000_DEAD;
        if (bus_mem.exists(a)) return bus_mem[a];
        return ~a;
    endfunction

    task automatic do_reset_mid();
        #2 wb_rst_i = 1'b1;
        #1;
        chk("rst_cyc", wbm_cyc_o, 0);
        chk("rst_stb", wbm_stb_o, 0);
        chk("rst_busy", busy_o, 0);
        chk("rst_rsp_valid", rsp_valid_o, 0);
        wbm_ack_i = 1'b0;
        @(negedge wb_clk_i);
        wb_rst_i = 1'b0;
        @(negedge wb_clk_i);
        chk("rst_cmd_ready_after", cmd_ready_o, 1);
    endtask

    // Called at a negedge with DUT idle. ack_lat = BUS cycle (1-based) carrying ack; 0 = never ack.
    task automatic run_cmd(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                           input int ack_lat, input int hold, input bit spur, input bit bp_cmd);
        int          n_stb;
        int          lim;
        bit          to_exp;
        logic [31:0] e_dat;
        to_exp = (ack_lat == 0);
        e_dat  = (we || to_exp) ? 32'h0 : model_rd(adr);
        lim    = 300;
`ifndef MOS_WBM_TIMEOUT_EN
        if (to_exp) lim = 110;
`endif
        chk("cmd_ready_idle", cmd_ready_o, 1);
        cmd_valid_i = 1'b1; cmd_we_i = we; cmd_adr_i = adr; cmd_dat_i = dat;
        @(negedge wb_clk_i);
        cmd_valid_i = 1'b0; cmd_adr_i = $urandom; cmd_dat_i = $urandom; cmd_we_i = ~we;
        chk("busy_bus", busy_o, 1);
        chk("cmd_ready_bus", cmd_ready_o, 0);
        n_stb = 0;
        for (int c = 0; c < lim; c++) begin
            if (!wbm_stb_o) break;
            n_stb++;
            chk("bus_cyc", wbm_cyc_o, 1);
            chk("bus_adr", wbm_adr_o, adr);
            chk("bus_we", wbm_we_o, we);
            chk("bus_sel", wbm_sel_o, 4'hF);
            if (we) chk("bus_dat", wbm_dat_o, dat);
            if (n_stb == ack_lat) begin
                wbm_ack_i = 1'b1;
                wbm_dat_i = resp_rd(wbm_adr_o);
                if (wbm_we_o) bus_mem[wbm_adr_o] = wbm_dat_o;
            end else begin
                wbm_dat_i = $urandom;
            end
            @(negedge wb_clk_i);
            wbm_ack_i = 1'b0;
        end
`ifndef MOS_WBM_TIMEOUT_EN
        if (to_exp) begin
            chk("stb_no_timeout", wbm_stb_o, 1);
            chk("stb_min100", (n_stb >= 100) ? 1 : 0, 1);
            do_reset_mid();
            return;
        end
`endif
        chk("stb_cycles", n_stb, to_exp ? TO : ack_lat);
        chk("cyc_drop", wbm_cyc_o, 0);
        chk("stb_drop", wbm_stb_o, 0);
        chk("sel_drop", wbm_sel_o, 0);
        chk("rsp_valid", rsp_valid_o, 1);
        chk("rsp_dat", rsp_dat_o, e_dat);
        chk("rsp_err", rsp_err_o, to_exp ? 1 : 0);
        chk("cmd_ready_resp", cmd_ready_o, 0);
        if (we && !to_exp) ref_mem[adr] = dat;
        for (int h = 0; h < hold; h++) begin
            if (bp_cmd) begin
                cmd_valid_i = 1'b1; cmd_we_i = 1'b1; cmd_adr_i = 32'h3000_0FF0; cmd_dat_i = 32'hDEAD_BEEF;
            end
            if (spur && h == 0) begin
                wbm_ack_i = 1'b1; wbm_dat_i = 32'h1234_5678;
            end
            @(negedge wb_clk_i);
            wbm_ack_i = 1'b0;
            chk("hold_rsp_valid", rsp_valid_o, 1);
            chk("hold_rsp_dat", rsp_dat_o, e_dat);
            chk("hold_rsp_err", rsp_err_o, to_exp ? 1 : 0);
            chk("hold_cmd_ready", cmd_ready_o, 0);
            chk("hold_cyc", wbm_cyc_o, 0);
        end
        cmd_valid_i = 1'b0;
        rsp_ready_i = 1'b1;
        @(negedge wb_clk_i);
        rsp_ready_i = 1'b0;
        chk("done_rsp_valid", rsp_valid_o, 0);
        chk("done_cmd_ready", cmd_ready_o, 1);
        chk("done_busy", busy_o, 0);
        chk("done_cyc", wbm_cyc_o, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        cmd_valid_i = 1'b0; cmd_we_i = 1'b0; cmd_adr_i = '0; cmd_dat_i = '0;
        rsp_ready_i = 1'b0; wbm_dat_i = '0; wbm_ack_i = 1'b0;
        wb_rst_i = 1'b1;
        #1;
        chk("reset_cyc", wbm_cyc_o, 0);
        chk("reset_stb", wbm_stb_o, 0);
        chk("reset_busy", busy_o, 0);
        chk("reset_rsp_valid", rsp_valid_o, 0);
        chk("reset_rsp_dat", rsp_dat_o, 0);
        chk("reset_adr", wbm_adr_o, 0);
        chk("reset_sel", wbm_sel_o, 0);
        chk("reset_cmd_ready", cmd_ready_o, 0);
        @(negedge wb_clk_i);
        @(negedge wb_clk_i);
        wb_rst_i = 1'b0;
        @(negedge wb_clk_i);
        chk("post_reset_cmd_ready", cmd_ready_o, 1);

        // instruction register write, ack one cycle after stb
        run_cmd(1'b1, 32'h3000_0000, 32'h0000_00A9, 2, 1, 1'b0, 1'b0);
        // ID read, ack on first bus cycle
        run_cmd(1'b0, ID_ADR, 32'h0, 1, 0, 1'b0, 1'b0);

        // spurious ack while idle
        wbm_ack_i = 1'b1; wbm_dat_i = 32'hFFFF_FFFF;
        @(negedge wb_clk_i);
        wbm_ack_i = 1'b0;
        chk("spur_idle_busy", busy_o, 0);
        chk("spur_idle_cyc", wbm_cyc_o, 0);
        chk("spur_idle_rsp_valid", rsp_valid_o, 0);
        chk("spur_idle_cmd_ready", cmd_ready_o, 1);

        // backpressure with a spurious ack in RESP and a competing command
        run_cmd(1'b0, 32'h3000_0000, 32'h0, 3, 5, 1'b1, 1'b1);

        // no-ack read: timeout abort, or endless wait when the counter is not built
        run_cmd(1'b0, 32'h3000_0100, 32'h0, 0, 2, 1'b0, 1'b0);

        // ack on the exact edge a timeout would fire, and one cycle before
        run_cmd(1'b0, 32'h3000_0000, 32'h0, TO, 1, 1'b0, 1'b0);
        run_cmd(1'b1, 32'h3000_0004, 32'hCAFE_F00D, TO - 1, 0, 1'b0, 1'b0);
        run_cmd(1'b0, 32'h3000_0004, 32'h0, 1, 0, 1'b0, 1'b0);

        // async reset mid-BUS
        chk("mid_cmd_ready", cmd_ready_o, 1);
        cmd_valid_i = 1'b1; cmd_we_i = 1'b1; cmd_adr_i = 32'h3000_0008; cmd_dat_i = 32'h5555_AAAA;
        @(negedge wb_clk_i);
        cmd_valid_i = 1'b0;
        @(negedge wb_clk_i);
        @(negedge wb_clk_i);
        chk("mid_stb_high", wbm_stb_o, 1);
        do_reset_mid();

        // randomized traffic over a small window of words
        for (int i = 0; i < 24; i++) begin
            run_cmd(1'($urandom_range(0, 1)), 32'h3000_0040 + 32'(4 * $urandom_range(0, 7)),
                    $urandom, $urandom_range(1, 4), $urandom_range(0, 3),
                    1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end
        for (int i = 0; i < 8; i++) begin
            run_cmd(1'b0, 32'h3000_0040 + 32'(4 * i), 32'h0, $urandom_range(1, 3), 0, 1'b0, 1'b0);
        end

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
